// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: shares the configuration SPI flash between the IROM boot
// loader (requester 0) and the run-time RISC-V SPI master (requester 1).
// Grants are level req/gnt, round-robin on contention, and every handover
// is separated by a chip-select-high gap of CS_GAP cycles (0 behaves as 1).
module spi_flash_arbiter #(
  parameter logic [7:0] CS_GAP = 8'd4
) (
  input  logic clk_i,
  input  logic crst_n,
  input  logic boot_done,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  input  logic m0_ss,
  input  logic m0_sck,
  input  logic m0_mosi,
  input  logic m1_ss,
  input  logic m1_sck,
  input  logic m1_mosi,
  output logic m0_miso,
  output logic m1_miso,
  output logic SPI_SS,
  output logic SPI_SCK,
  output logic SPI_SO,
  input  logic SPI_SI,
  output logic busy,
  output logic last_owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Gap counter reload; a zero gap still spends one cycle in GAP.
  localparam logic [7:0] GAP_LOAD = (CS_GAP == 8'd0) ? 8'd0 : (CS_GAP - 8'd1);

  state_e     state_q, state_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       busy_q, busy_d;
  logic       last_owner_q, last_owner_d;
  logic       r0, r1;

  // Requester 1 is invisible until the boot loader has finished.
  assign r0 = req0;
  assign r1 = req1 & boot_done;

  // Next-state, gap counter and registered-output decode.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (r0 && r1) begin
          state_d = last_owner_q ? GNT0 : GNT1;
        end else if (r0) begin
          state_d = GNT0;
        end else if (r1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!req0) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      GNT1: begin
        if (!req1) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q == IDLE && state_d == GNT0) last_owner_d = 1'b0;
    if (state_q == IDLE && state_d == GNT1) last_owner_d = 1'b1;
    gnt0_d = (state_d == GNT0);
    gnt1_d = (state_d == GNT1);
    busy_d = (state_d != IDLE);
  end

  // State machine and registered outputs, asynchronously reset to idle.
  always_ff @(posedge clk_i or negedge crst_n) begin
    if (!crst_n) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      busy_q       <= 1'b0;
      last_owner_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      busy_q       <= busy_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign busy       = busy_q;
  assign last_owner = last_owner_q;

  // Flash pin mux from the registered state; unowned pins sit at idle level.
  always_comb begin
    SPI_SS  = 1'b1;
    SPI_SCK = 1'b0;
    SPI_SO  = 1'b0;
    m0_miso = 1'b0;
    m1_miso = 1'b0;
    case (state_q)
      GNT0: begin
        SPI_SS  = m0_ss;
        SPI_SCK = m0_sck;
        SPI_SO  = m0_mosi;
        m0_miso = SPI_SI;
      end
      GNT1: begin
        SPI_SS  = m1_ss;
        SPI_SCK = m1_sck;
        SPI_SO  = m1_mosi;
        m1_miso = SPI_SI;
      end
      default: begin
        SPI_SS  = 1'b1;
        SPI_SCK = 1'b0;
        SPI_SO  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: default CS_GAP=4 instance plus
// CS_GAP=0 and CS_GAP=8 instances driven by the same stimulus.
module tb_spi_flash_arbiter;

  logic clk_i = 1'b0;
  logic crst_n, boot_done, req0, req1;
  logic m0_ss, m0_sck, m0_mosi, m1_ss, m1_sck, m1_mosi, SPI_SI;

  logic gnt0, gnt1, m0_miso, m1_miso, SPI_SS, SPI_SCK, SPI_SO, busy, last_owner;
  logic z_gnt0, z_gnt1, z_m0_miso, z_m1_miso, z_ss, z_sck, z_so, z_busy, z_lo;
  logic e_gnt0, e_gnt1, e_m0_miso, e_m1_miso, e_ss, e_sck, e_so, e_busy, e_lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  spi_flash_arbiter u_dut (
    .clk_i(clk_i), .crst_n(crst_n), .boot_done(boot_done), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1), .m0_ss(m0_ss), .m0_sck(m0_sck), .m0_mosi(m0_mosi),
    .m1_ss(m1_ss), .m1_sck(m1_sck), .m1_mosi(m1_mosi), .m0_miso(m0_miso),
    .m1_miso(m1_miso), .SPI_SS(SPI_SS), .SPI_SCK(SPI_SCK), .SPI_SO(SPI_SO),
    .SPI_SI(SPI_SI), .busy(busy), .last_owner(last_owner)
  );

  spi_flash_arbiter #(.CS_GAP(8'd0)) u_gap0 (
    .clk_i(clk_i), .crst_n(crst_n), .boot_done(boot_done), .req0(req0), .req1(req1),
    .gnt0(z_gnt0), .gnt1(z_gnt1), .m0_ss(m0_ss), .m0_sck(m0_sck), .m0_mosi(m0_mosi),
    .m1_ss(m1_ss), .m1_sck(m1_sck), .m1_mosi(m1_mosi), .m0_miso(z_m0_miso),
    .m1_miso(z_m1_miso), .SPI_SS(z_ss), .SPI_SCK(z_sck), .SPI_SO(z_so),
    .SPI_SI(SPI_SI), .busy(z_busy), .last_owner(z_lo)
  );

  spi_flash_arbiter #(.CS_GAP(8'd8)) u_gap8 (
    .clk_i(clk_i), .crst_n(crst_n), .boot_done(boot_done), .req0(req0), .req1(req1),
    .gnt0(e_gnt0), .gnt1(e_gnt1), .m0_ss(m0_ss), .m0_sck(m0_sck), .m0_mosi(m0_mosi),
    .m1_ss(m1_ss), .m1_sck(m1_sck), .m1_mosi(m1_mosi), .m0_miso(e_m0_miso),
    .m1_miso(e_m1_miso), .SPI_SS(e_ss), .SPI_SCK(e_sck), .SPI_SO(e_so),
    .SPI_SI(SPI_SI), .busy(e_busy), .last_owner(e_lo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    crst_n = 1'b0;
    boot_done = 1'b0; req0 = 1'b0; req1 = 1'b0;
    m0_ss = 1'b1; m0_sck = 1'b0; m0_mosi = 1'b0;
    m1_ss = 1'b1; m1_sck = 1'b0; m1_mosi = 1'b0;
    SPI_SI = 1'b0;
    tick();
    tick();
    crst_n = 1'b1;
  endtask

  // Wait (bounded) until all three instances are back in IDLE.
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || z_busy || e_busy) && n < 40) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy | z_busy | e_busy}, 32'd0);
  endtask

  initial begin
    int n, first_z, first_d, first_e, gd, gz, ge;
    logic ss_low;
    logic [3:0] owners;

    // ---- asynchronous reset values, no clock edge yet ----
    crst_n = 1'b0;
    boot_done = 1'b0; req0 = 1'b0; req1 = 1'b0;
    m0_ss = 1'b0; m0_sck = 1'b1; m0_mosi = 1'b1;
    m1_ss = 1'b0; m1_sck = 1'b1; m1_mosi = 1'b1;
    SPI_SI = 1'b1;
    #1;
    check("rst_vals", {23'd0, gnt0, gnt1, busy, last_owner, SPI_SS, SPI_SCK, SPI_SO, m0_miso, m1_miso},
          32'b0_0_0_0_1_0_0_0_0);

    // ---- boot sequence ----
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("boot_gnt0_lat", {30'd0, gnt0, gnt1}, 32'b10);
    for (int i = 0; i < 100; i++) begin
      m0_ss = 1'b0; m0_sck = i[0]; m0_mosi = i[1];
      if (i == 60) boot_done = 1'b1;
      tick();
      if (i == 7) check("boot_pins_follow_m0", {29'd0, SPI_SS, SPI_SCK, SPI_SO}, 32'b011);
      if (gnt1) check("boot_gnt1_early", 32'd1, 32'd0);
    end
    check("boot_gnt1_held", {31'd0, gnt1}, 32'd0);
    req0 = 1'b0;
    tick();  // edge j
    check("boot_release", {29'd0, gnt0, SPI_SS, busy}, 32'b011);
    first_d = -1; first_z = -1; first_e = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (gnt1   && first_d < 0) first_d = k;
      if (z_gnt1 && first_z < 0) first_z = k;
      if (e_gnt1 && first_e < 0) first_e = k;
    end
    check("boot_gnt1_delay", first_d, 32'd5);
    check("boot_gnt1_delay_gap0", first_z, 32'd2);
    check("boot_gnt1_delay_gap8", first_e, 32'd9);
    check("boot_last_owner", {31'd0, last_owner}, 32'd1);

    // ---- isolation in GNT1 ----
    m0_ss = 1'b0; m0_sck = 1'b1; m0_mosi = 1'b1;
    m1_ss = 1'b0; m1_sck = 1'b0; m1_mosi = 1'b0;
    SPI_SI = 1'b1;
    #1;
    check("iso_pins_a", {27'd0, SPI_SS, SPI_SCK, SPI_SO, m0_miso, m1_miso}, 32'b00001);
    m1_ss = 1'b1; m1_sck = 1'b1; m1_mosi = 1'b1; m0_ss = 1'b1; m0_sck = 1'b0; m0_mosi = 1'b0;
    #1;
    check("iso_pins_b", {29'd0, SPI_SS, SPI_SCK, SPI_SO}, 32'b111);
    req1 = 1'b0;
    wait_idle("boot_idle_timeout");

    // ---- simultaneous requests, round-robin ----
    do_reset();
    boot_done = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("sim_first_gnt1", {30'd0, gnt0, gnt1}, 32'b01);
    req1 = 1'b0;
    n = 0;
    while (!gnt0 && n < 20) begin
      if (gnt1 && n > 0) check("sim_gnt_overlap", 32'd1, 32'd0);
      tick();
      n++;
    end
    check("sim_then_gnt0", {30'd0, gnt0, gnt1}, 32'b10);
    check("sim_then_gnt0_delay", n, 32'd6);
    req0 = 1'b0;
    wait_idle("sim_idle_timeout");
    for (int r = 0; r < 4; r++) begin
      req0 = 1'b1; req1 = 1'b1;
      tick();
      owners[r] = gnt1;
      req0 = 1'b0; req1 = 1'b0;
      tick();
      wait_idle("rr_idle_timeout");
    end
    check("rr_owners", {28'd0, owners}, 32'b0101);

    // ---- gap enforcement with req0 dropped while m0_ss low ----
    do_reset();
    req0 = 1'b1;
    tick();
    m0_ss = 1'b0;
    tick();
    check("gap_ss_owned", {29'd0, SPI_SS, z_ss, e_ss}, 32'b000);
    req0 = 1'b0;
    tick();  // edge j: all in GAP
    check("gap_ss_forced", {26'd0, SPI_SS, z_ss, e_ss, busy, z_busy, e_busy}, 32'b111111);
    gd = 1; gz = 1; ge = 1; ss_low = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (busy) gd++;
      if (z_busy) gz++;
      if (e_busy) ge++;
      if (!SPI_SS || !z_ss || !e_ss) ss_low = 1'b1;
    end
    check("gap_len_4", gd, 32'd4);
    check("gap_len_0", gz, 32'd1);
    check("gap_len_8", ge, 32'd8);
    check("gap_ss_stays_high", {31'd0, ss_low}, 32'd0);

    // ---- one-cycle request pulse ----
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    check("pulse_gnt", {31'd0, gnt0}, 32'd1);
    tick();
    check("pulse_gap", {30'd0, gnt0, busy}, 32'b01);
    wait_idle("pulse_idle_timeout");

    // ---- asynchronous reset mid-transfer ----
    req0 = 1'b1; m0_ss = 1'b0;
    tick();
    check("arst_pre", {29'd0, gnt0, busy, SPI_SS}, 32'b110);
    #2;
    crst_n = 1'b0;
    #1;
    check("arst_immediate", {29'd0, gnt0, busy, SPI_SS}, 32'b001);
    #2;
    crst_n = 1'b1;
    #1;
    check("arst_after_release", {31'd0, gnt0}, 32'd0);
    tick();
    check("arst_regrant", {30'd0, gnt0, busy}, 32'b11);
    req0 = 1'b0;
    wait_idle("arst_idle_timeout");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Grants must never overlap in any instance.
  always @(negedge clk_i) begin
    if (crst_n && ((gnt0 && gnt1) || (z_gnt0 && z_gnt1) || (e_gnt0 && e_gnt1)))
      check("gnt_exclusive", 32'd1, 32'd0);
  end

endmodule
